irq_ctrl: RTL and testbench

//  Interrupt request controller directly upstream of the Processor's `interupt` input.

---
 rtl/irq_ctrl_pkg.sv | 18 +
 rtl/irq_ctrl_sync.sv | 36 +++
 rtl/irq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg
//   Shared types and constants for the interrupt request controller.
//   - irq_state_e : handshake FSM state (IDLE -> REQ -> SERVICE -> IDLE)
//   - CFG_*       : cfg_addr map of the configuration port
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] CFG_ENABLE = 2'd0;
  localparam logic [1:0] CFG_EDGE   = 2'd1;
  localparam logic [1:0] CFG_PEND   = 2'd2;
  localparam logic [1:0] CFG_STATUS = 2'd3;

endpackage

// File: rtl/irq_ctrl_sync.sv
// irq_sync
//   Brings one asynchronous interrupt line into the clk domain and flags its
//   rising edge.
// Ports:
//   clk    in   core clock, rising edge
//   rst    in   synchronous active-low reset
//   src    in   raw asynchronous interrupt line
//   level  out  synchronized level (last flop of the chain)
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chain_reg <= '0;
      prev_reg  <= 1'b0;
    end else begin
      chain_reg <= {chain_reg[SYNC_STAGES-2:0], src};
      prev_reg  <= chain_reg[SYNC_STAGES-1];
    end
  end

  assign level = chain_reg[SYNC_STAGES-1];
  assign rise  = chain_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl
//   Interrupt request controller feeding the core's interupt input.
//   Synchronizes NUM_SRC external lines, applies per-source enable and
//   edge/level mode, latches pending requests, picks the lowest pending
//   enabled index and runs a request/ack/done handshake with the core.
// Ports:
//   clk        in   core clock, rising edge
//   rst        in   synchronous active-low reset
//   irq_src    in   raw asynchronous interrupt lines, active-high
//   cfg_we     in   config write strobe
//   cfg_addr   in   0=ENABLE 1=EDGE_MODE 2=PENDING(W1C) 3=STATUS(RO)
//   cfg_wdata  in   config write data
//   cfg_rdata  out  combinational read of cfg_addr
//   interupt   out  registered request to the core
//   irq_id     out  registered index of requested / in-service source
//   irq_ack    in   core took the trap for irq_id (1-cycle pulse)
//   irq_done   in   core executed mret for the in-service source (pulse)
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter  int NUM_SRC     = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic [NUM_SRC-1:0] cfg_rdata,
  output logic               interupt,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_done
);

  localparam int ST_W = ID_W + 2;

  logic [NUM_SRC-1:0] level_vec;
  logic [NUM_SRC-1:0] rise_vec;
  logic [NUM_SRC-1:0] enable_reg;
  logic [NUM_SRC-1:0] edge_reg;
  logic [NUM_SRC-1:0] pend_reg;
  logic [NUM_SRC-1:0] pend_next;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] ack_mask;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] status_ext;
  logic [ST_W-1:0]    status_vec;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    irq_id_reg;
  logic [ID_W-1:0]    irq_id_next;
  logic               interupt_reg;
  logic               interupt_next;
  logic               ack_take;
  irq_state_e         state_reg;
  irq_state_e         state_next;

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
    lowest_set = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ID_W'(i);
    end
  endfunction

  // ---------------------------------------------------------------- sources
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .src  (irq_src[gi]),
      .level(level_vec[gi]),
      .rise (rise_vec[gi])
    );
  end

  // ---------------------------------------------------------------- pending
  // An ack only counts while a request is actually outstanding.
  assign ack_take = (state_reg == REQ) && irq_ack;
  assign ack_mask = ack_take ? (NUM_SRC'(1) << irq_id_reg) : '0;
  assign w1c_mask = (cfg_we && (cfg_addr == CFG_PEND)) ? cfg_wdata : '0;

  // Edge bits: a new rise beats any clear in the same cycle.
  // Level bits: simply track the synchronized line every cycle.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
    assign pend_next[gi] = edge_reg[gi]
                         ? (rise_vec[gi] | (pend_reg[gi] & ~(w1c_mask[gi] | ack_mask[gi])))
                         : level_vec[gi];
  end

  assign eligible = pend_reg & enable_reg;
  assign winner   = lowest_set(eligible);

  // ------------------------------------------------------ config + pending
  always_ff @(posedge clk) begin
    if (!rst) begin
      enable_reg <= '0;
      edge_reg   <= '1;
      pend_reg   <= '0;
    end else begin
      if (cfg_we && (cfg_addr == CFG_ENABLE)) enable_reg <= cfg_wdata;
      if (cfg_we && (cfg_addr == CFG_EDGE))   edge_reg   <= cfg_wdata;
      pend_reg <= pend_next;
    end
  end

  // ------------------------------------------------------------ FSM: state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      irq_id_reg   <= '0;
      interupt_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      irq_id_reg   <= irq_id_next;
      interupt_reg <= interupt_next;
    end
  end

  // ------------------------------------------------------- FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (|eligible) state_next = REQ;
      end
      REQ: begin
        // Ack takes priority over a simultaneous withdrawal.
        if (irq_ack)                    state_next = SERVICE;
        else if (!eligible[irq_id_reg]) state_next = IDLE;
      end
      SERVICE: begin
        if (irq_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ----------------------------------------------------------- FSM: outputs
  // The id is only re-chosen in IDLE so it stays frozen through REQ/SERVICE.
  always_comb begin
    irq_id_next   = irq_id_reg;
    interupt_next = (state_next == REQ);
    if ((state_reg == IDLE) && (|eligible)) irq_id_next = winner;
  end

  assign interupt = interupt_reg;
  assign irq_id   = irq_id_reg;

  // ---------------------------------------------------------------- readback
  assign status_vec = {state_reg, irq_id_reg};

  // Zero-extend (or truncate for very small NUM_SRC) the status word.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_status
    if (gi < ST_W) begin : g_bit
      assign status_ext[gi] = status_vec[gi];
    end else begin : g_zero
      assign status_ext[gi] = 1'b0;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      CFG_ENABLE: cfg_rdata = enable_reg;
      CFG_EDGE:   cfg_rdata = edge_reg;
      CFG_PEND:   cfg_rdata = pend_reg;
      CFG_STATUS: cfg_rdata = status_ext;
      default:    cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl
//   Directed bench for irq_ctrl. Each expected request (id + the cycle at
//   which interupt must rise) is queued when its stimulus is issued; an
//   independent monitor pops and compares whenever interupt rises.
//   Register/level checks are made directly against hand-computed values.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq_src = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [7:0] cfg_rdata;
  logic       interupt;
  logic [2:0] irq_id;
  logic       irq_ack = 1'b0;
  logic       irq_done = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int id;
    int cyc;
  } exp_t;
  exp_t exp_q[$];
  logic prev_int = 1'b0;

  irq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .irq_src  (irq_src),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .interupt (interupt),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack),
    .irq_done (irq_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [7:0] e);
    cfg_addr = a;
    #1;
    chk(name, int'(cfg_rdata), int'(e));
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  task automatic expect_req(input int id, input int dly);
    exp_t e;
    e.id  = id;
    e.cyc = cyc + dly;
    exp_q.push_back(e);
  endtask

  // Monitor: compares each rising edge of interupt against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (interupt && !prev_int) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got id %0d at cycle %0d, required no request", irq_id, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("req_id", int'(irq_id), e.id);
        chk("req_cycle", cyc, e.cyc);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_req: no request for id %0d by cycle %0d, required at cycle %0d",
               e.id, cyc, e.cyc);
    end
    prev_int = interupt;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- reset values
    tick(3);
    chk("rst_interupt", int'(interupt), 0);
    chk("rst_irq_id", int'(irq_id), 0);
    chk_reg("rst_enable", 2'd0, 8'h00);
    chk_reg("rst_edge", 2'd1, 8'hFF);
    chk_reg("rst_pend", 2'd2, 8'h00);
    chk_reg("rst_status", 2'd3, 8'h00);
    rst = 1'b1;
    tick();

    // ---- 1: single edge source, latency and handshake
    wr(2'd0, 8'h04);
    expect_req(2, 4);
    irq_src[2] = 1'b1;
    tick(3);
    irq_src[2] = 1'b0;
    tick();
    chk("t1_interupt", int'(interupt), 1);
    chk_reg("t1_status_req", 2'd3, 8'h0A);
    pulse_ack();
    chk("t1_int_after_ack", int'(interupt), 0);
    chk_reg("t1_status_svc", 2'd3, 8'h12);
    chk_reg("t1_pend_cleared", 2'd2, 8'h00);
    pulse_done();
    chk_reg("t1_status_idle", 2'd3, 8'h02);

    // ---- 2: simultaneous sources, priority and back-to-back
    wr(2'd0, 8'hFF);
    expect_req(1, 4);
    irq_src[1] = 1'b1;
    irq_src[5] = 1'b1;
    tick(4);
    chk_reg("t2_pend", 2'd2, 8'h22);
    pulse_ack();
    expect_req(5, 2);
    pulse_done();
    chk("t2_idle_gap", int'(interupt), 0);
    tick();
    chk("t2_second_req", int'(interupt), 1);
    pulse_ack();
    pulse_done();
    irq_src = '0;
    tick();
    chk_reg("t2_pend_empty", 2'd2, 8'h00);

    // ---- 3: level mode re-request and withdrawal
    wr(2'd1, 8'hF7);
    expect_req(3, 4);
    irq_src[3] = 1'b1;
    tick(4);
    pulse_ack();
    chk_reg("t3_pend_level", 2'd2, 8'h08);
    expect_req(3, 2);
    pulse_done();
    tick();
    chk("t3_rereq", int'(interupt), 1);
    irq_src[3] = 1'b0;
    tick(3);
    chk("t3_still_req", int'(interupt), 1);
    tick();
    chk("t3_withdrawn", int'(interupt), 0);
    chk_reg("t3_status_idle", 2'd3, 8'h03);
    wr(2'd1, 8'hFF);

    // ---- withdrawal by disabling the requested source
    expect_req(0, 4);
    irq_src[0] = 1'b1;
    tick(3);
    irq_src[0] = 1'b0;
    tick();
    wr(2'd0, 8'hFE);
    chk("dis_req_held", int'(interupt), 1);
    tick();
    chk("dis_withdrawn", int'(interupt), 0);
    chk_reg("dis_status", 2'd3, 8'h00);
    chk_reg("dis_pend_kept", 2'd2, 8'h01);
    wr(2'd2, 8'h01);
    chk_reg("dis_pend_w1c", 2'd2, 8'h00);
    wr(2'd0, 8'hFF);

    // ---- 4: W1C of requested bit together with ack, ack wins
    expect_req(4, 4);
    irq_src[4] = 1'b1;
    tick(3);
    irq_src[4] = 1'b0;
    tick();
    irq_ack   = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = 2'd2;
    cfg_wdata = 8'h10;
    tick();
    irq_ack   = 1'b0;
    cfg_we    = 1'b0;
    cfg_wdata = '0;
    chk("t4_int", int'(interupt), 0);
    chk_reg("t4_status_svc", 2'd3, 8'h14);
    chk_reg("t4_pend", 2'd2, 8'h00);
    pulse_done();

    // ---- 5: stray done in IDLE, stray ack in SERVICE
    pulse_done();
    chk_reg("t5_status_idle", 2'd3, 8'h04);
    chk("t5_int_idle", int'(interupt), 0);
    expect_req(6, 4);
    irq_src[6] = 1'b1;
    tick(3);
    irq_src[6] = 1'b0;
    tick();
    pulse_ack();
    chk_reg("t5_status_svc", 2'd3, 8'h16);
    pulse_ack();
    chk_reg("t5_status_svc_ack", 2'd3, 8'h16);

    // ---- 6: reset while in SERVICE with other requests pending
    irq_src[5] = 1'b1;
    irq_src[7] = 1'b1;
    tick(3);
    chk_reg("t6_pend", 2'd2, 8'hA0);
    chk_reg("t6_status_svc", 2'd3, 8'h16);
    rst = 1'b0;
    tick();
    chk("t6_interupt", int'(interupt), 0);
    chk("t6_irq_id", int'(irq_id), 0);
    chk_reg("t6_pend", 2'd2, 8'h00);
    chk_reg("t6_enable", 2'd0, 8'h00);
    chk_reg("t6_status", 2'd3, 8'h00);
    irq_src = '0;
    rst = 1'b1;
    tick(6);
    chk("t6_quiet", int'(interupt), 0);

    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
